// File: rtl/ddr_tx_pkg.sv
// Shared types for the DDR transmit serializer: FSM states and beat counter sizing.
package ddr_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must hold 0..beats-1 and never collapse to zero width.
  function automatic int beat_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/oddr_cell.sv
// Behavioural DDR output cell: rise bit while clk high, fall bit while clk low.
// Zero latency (combinational mux); no backpressure.
module oddr_cell (
  input  logic clk,
  input  logic d_rise,
  input  logic d_fall,
  output logic q
);

  assign q = clk ? d_rise : d_fall;

endmodule

// File: rtl/ddr_tx_serializer.sv
// DDR transmit serializer: parallel word -> LANES DDR pins, LSB beat first. Optional DDR_TX_TRAINING_EN.
// Latency: beat 0 on pins the cycle after the accepting edge; one beat per clk.
// Backpressure: in_ready only in IDLE or on the last beat, so back-to-back words stream gap-free.
module ddr_tx_serializer
  import ddr_tx_pkg::*;
#(
  parameter int   LANES    = 2,
  parameter int   BEATS    = 4,
  parameter logic IDLE_VAL = 1'b0,
  parameter int   DATA_W   = 2 * LANES * BEATS
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LANES-1:0]  ddr_q,
  output logic              tx_frame,
  output logic              busy
`ifdef DDR_TX_TRAINING_EN
  ,
  input  logic              train_req,
  output logic              train_active
`endif
);

  localparam int             CW     = beat_cnt_w(BEATS);
  localparam int             BEAT_W = 2 * LANES;
  localparam logic [CW-1:0]  LAST   = CW'(BEATS - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LANES-1:0]   rise_q, rise_d, fall_q, fall_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               frame_q, frame_d;
  logic               rdy_en_q;
  logic               last_beat, xfer;
`ifdef DDR_TX_TRAINING_EN
  logic               train_q, train_d;
`endif

  always_comb begin
    last_beat = (state_q == SHIFT) && (cnt_q == LAST);
    in_ready  = rdy_en_q && ((state_q == IDLE) || last_beat);
    xfer      = in_valid && in_ready;

    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    frame_d = frame_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
`ifdef DDR_TX_TRAINING_EN
    train_d = 1'b0;
`endif

    if (xfer) begin
      for (int l = 0; l < LANES; l++) begin
        rise_d[l] = in_data[2*l];
        fall_d[l] = in_data[2*l+1];
      end
      shift_d = in_data >> BEAT_W;
      cnt_d   = '0;
      state_d = SHIFT;
      frame_d = 1'b1;
    end else if ((state_q == SHIFT) && !last_beat) begin
      for (int l = 0; l < LANES; l++) begin
        rise_d[l] = shift_q[2*l];
        fall_d[l] = shift_q[2*l+1];
      end
      shift_d = shift_q >> BEAT_W;
      cnt_d   = cnt_q + 1'b1;
    end else begin
      rise_d  = {LANES{IDLE_VAL}};
      fall_d  = {LANES{IDLE_VAL}};
      frame_d = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
`ifdef DDR_TX_TRAINING_EN
      // Forwarded-clock pattern lets the far end align its capture while no data flows.
      if ((state_q == IDLE) && train_req) begin
        rise_d  = {LANES{1'b1}};
        fall_d  = {LANES{1'b0}};
        train_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      frame_q  <= 1'b0;
      rise_q   <= {LANES{IDLE_VAL}};
      fall_q   <= {LANES{IDLE_VAL}};
      rdy_en_q <= 1'b0;
`ifdef DDR_TX_TRAINING_EN
      train_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      frame_q  <= frame_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      rdy_en_q <= 1'b1;
`ifdef DDR_TX_TRAINING_EN
      train_q  <= train_d;
`endif
    end
  end

  assign tx_frame = frame_q;
  assign busy     = (state_q == SHIFT);
`ifdef DDR_TX_TRAINING_EN
  assign train_active = train_q;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    oddr_cell u_oddr (
      .clk    (clk),
      .d_rise (rise_q[l]),
      .d_fall (fall_q[l]),
      .q      (ddr_q[l])
    );
  end

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Scoreboard bench for ddr_tx_serializer (LANES=2, BEATS=4); training checks under DDR_TX_TRAINING_EN.
module tb_ddr_tx_serializer;

  localparam int LANES  = 2;
  localparam int BEATS  = 4;
  localparam int DATA_W = 2 * LANES * BEATS;
  localparam logic [LANES-1:0] IDLE_PAT = '0;

  typedef struct packed {
    logic [LANES-1:0] r;
    logic [LANES-1:0] f;
  } beat_t;

  logic              clk = 1'b0;
  logic              resetb = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [LANES-1:0]  ddr_q;
  logic              tx_frame;
  logic              busy;
`ifdef DDR_TX_TRAINING_EN
  logic              train_req = 1'b0;
  logic              train_active;
`endif

  ddr_tx_serializer #(.LANES(LANES), .BEATS(BEATS), .IDLE_VAL(1'b0)) dut (
    .clk      (clk),
    .resetb   (resetb),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ddr_q    (ddr_q),
    .tx_frame (tx_frame),
    .busy     (busy)
`ifdef DDR_TX_TRAINING_EN
    ,
    .train_req    (train_req),
    .train_active (train_active)
`endif
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t sb[$];
  bit    mon_en = 1'b0;
  int    frames = 0;
  int    run = 0;
  int    max_run = 0;
  int    low_run = 0;
  int    last_gap = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one word; returns the number of cycles spent waiting for in_ready.
  task automatic send(input logic [DATA_W-1:0] w, output int waits);
    beat_t e;
    waits    = 0;
    in_valid = 1'b1;
    in_data  = w;
    #1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (waits >= 50) chk("send_timeout", 32'(in_ready), 32'd1);
    for (int b = 0; b < BEATS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        e.r[l] = w[2*(b*LANES+l)];
        e.f[l] = w[2*(b*LANES+l)+1];
      end
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    beat_t e;
    bit    skip_idle;
    #2;
    if (mon_en) begin
      skip_idle = 1'b0;
`ifdef DDR_TX_TRAINING_EN
      skip_idle = train_req;
`endif
      if (tx_frame) begin
        frames++;
        run++;
        if (run > max_run) max_run = run;
        if (low_run > 0) last_gap = low_run;
        low_run = 0;
        chk("frame_has_expect", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rise_beat", 32'(ddr_q), 32'(e.r));
          @(negedge clk);
          #2;
          if (mon_en) chk("fall_beat", 32'(ddr_q), 32'(e.f));
        end
      end else begin
        run = 0;
        low_run++;
        if (!skip_idle) begin
          chk("idle_rise", 32'(ddr_q), 32'(IDLE_PAT));
          @(negedge clk);
          #2;
          if (mon_en) chk("idle_fall", 32'(ddr_q), 32'(IDLE_PAT));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int f0;
    logic [DATA_W-1:0] word;

    // Reset state, both clock phases
    @(posedge clk); #2;
    chk("rst_ddr_rise", 32'(ddr_q), 32'(IDLE_PAT));
    chk("rst_frame", 32'(tx_frame), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); #2;
    chk("rst_ddr_fall", 32'(ddr_q), 32'(IDLE_PAT));
    @(negedge clk);
    resetb = 1'b1;
    #1 chk("ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_release", 32'(in_ready), 32'd1);
    mon_en = 1'b1;
    @(negedge clk);

    // Single word
    max_run = 0;
    f0 = frames;
    send(16'hA5C3, w);
    chk("single_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("single_frames", 32'(frames - f0), 32'd4);
    chk("single_run", 32'(max_run), 32'd4);
    chk("single_sb_empty", 32'(sb.size()), 32'd0);
    chk("single_ready_idle", 32'(in_ready), 32'd1);
    chk("single_busy_idle", 32'(busy), 32'd0);

    // Back-to-back
    max_run = 0;
    send(16'h1234, w);
    send(16'h5678, w);
    chk("b2b_ready_wait", 32'(w), 32'd3);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("b2b_run", 32'(max_run), 32'd8);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Two-cycle stall between words
    send(16'hF00F, w);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    send(16'h0FF0, w);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("stall_gap", 32'(last_gap), 32'd2);
    chk("stall_sb_empty", 32'(sb.size()), 32'd0);

    // Random words with random gaps
    for (int i = 0; i < 6; i++) begin
      word = DATA_W'($urandom);
      send(word, w);
      if ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-word at beat 2
    send(16'hFFFF, w);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    resetb = 1'b0;
    #1;
    chk("mid_rst_ddr_rise", 32'(ddr_q), 32'(IDLE_PAT));
    chk("mid_rst_frame", 32'(tx_frame), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); #2;
    chk("mid_rst_ddr_fall", 32'(ddr_q), 32'(IDLE_PAT));
    sb.delete();
    @(negedge clk);
    resetb = 1'b1;
    f0 = frames;
    mon_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_residual", 32'(frames - f0), 32'd0);
    chk("mid_rst_ready_back", 32'(in_ready), 32'd1);

`ifdef DDR_TX_TRAINING_EN
    // Training pattern then data takes over
    train_req = 1'b1;
    @(posedge clk); #2;
    chk("train_rise", 32'(ddr_q), 32'h3);
    chk("train_active_on", 32'(train_active), 32'd1);
    chk("train_frame", 32'(tx_frame), 32'd0);
    @(negedge clk); #2;
    chk("train_fall", 32'(ddr_q), 32'h0);
    @(negedge clk);
    send(16'h9C36, w);
    train_req = 1'b0;
    in_valid  = 1'b0;
    chk("train_active_off", 32'(train_active), 32'd0);
    repeat (6) @(negedge clk);
    chk("train_sb_empty", 32'(sb.size()), 32'd0);
`endif

    mon_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
